fsm_par_ctrl: RTL and testbench
===============================

Name: fsm_par_ctrl

Overview:
- Parallel-composition controller: launches N child enable FSMs together and asserts ready once every enabled child has reported ready.
- Sits beside the sequential controller: its valid/ready pair plugs into one slot of a sequencer; its per-child valid/ready pairs drive group-enable FSMs such as register/constant enable groups.
- Tracks per-child completion with sticky done bits, so children finishing on different cycles are handled.

Parameters:
- N, 2, number of child enables (N >= 1 legal).
- TIMEOUT, 1024, RUN-cycle limit when the watchdog is compiled in (>= 1).
- CNT_W, 16, watchdog counter width; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- valid  in  1  parent request; held high for the whole operation.
- child_en  in  N  per-child enable mask, sampled only on the IDLE->RUN transition.
- ready_child  in  N  child i ready; ignored unless valid_child[i]=1.
- valid_child  out  N  child i launch request.
- ready  out  1  all enabled children complete.
- done_vec  out  N  sticky per-child done bits (debug/status).
- error  out  1  watchdog expired; forced 0 when the feature is absent.

Behaviour:
- Reset (async assert): state=IDLE, done=0, counter=0. Outputs ready=0, valid_child=0, done_vec=0, error=0.
- All outputs are Moore outputs decoded from registered state and done bits. No combinational path from valid to any output.
- IDLE:
  - Outputs all 0.
  - valid=1 -> RUN. On that edge, done <= ~child_en (disabled children pre-marked done) and counter <= 0.
- RUN:
  - valid_child[i] = ~done[i].
  - done[i] sets on any edge where valid_child[i] & ready_child[i].
  - Go to DONE when (done | (valid_child & ready_child)) is all ones. Children completing in the same cycle count together.
  - valid=0 in RUN (abort) -> IDLE next edge, done cleared. Abort takes priority over completion in the same cycle.
- DONE:
  - ready=1, valid_child=0, done_vec all ones.
  - Stays in DONE while valid=1.
  - valid=0 -> IDLE, done cleared, ready drops the next cycle.
- Latency:
  - valid sampled high in IDLE at edge t -> valid_child high from t+1.
  - If every child returns ready in the first RUN cycle -> ready high from t+2.
  - Minimum 2 cycles from valid to ready.
- All children masked (child_en=0) -> RUN lasts exactly 1 cycle with no valid_child, then DONE.
- Child ready high before launch has no effect. It is counted only in a cycle where that child's valid_child is high.
- child_en changes after launch have no effect until the next IDLE->RUN.
- Illegal state encodings -> IDLE.

Optional Feature:
- Macro FSM_PAR_TIMEOUT_EN.
- Defined:
  - CNT_W counter increments every RUN cycle, clears on entry to RUN.
  - If the counter reaches TIMEOUT-1 while the completion condition is false: next state DONE, error=1, pending valid_child drop.
  - error stays 1 for the whole DONE period and clears on return to IDLE or on reset.
  - Normal completion in the expiring cycle wins: DONE with error=0.
- Undefined: no counter logic is synthesised, error is tied to 0, and RUN waits indefinitely.

Test Plan:
- N=3, child_en=3'b111, valid held high; children ready on RUN cycles 1,3,2 respectively -> valid_child drops per child on its ready; ready rises exactly one cycle after RUN cycle 3; done_vec=3'b111.
- N=3, child_en=3'b111, all ready_child tied high -> valid_child=3'b111 for exactly 1 cycle; ready high 2 cycles after valid rises.
- N=3, child_en=3'b101 -> valid_child[1] never asserts; ready follows child 0 and child 2 only. child_en=3'b000 -> ready 2 cycles after valid with zero valid_child pulses.
- Abort: deassert valid while child 2 is pending (done_vec=3'b011) -> IDLE next edge, valid_child=0, done_vec=0. Relaunch succeeds normally.
- Reset asserted asynchronously mid-RUN and mid-DONE -> all outputs 0 immediately, without waiting for a clock edge. After release, valid relaunches from IDLE.
- FSM_PAR_TIMEOUT_EN, TIMEOUT=8, child 1 never ready -> DONE after 8 RUN cycles with ready=1, error=1, done_vec[1]=0. Same setup with child 1 ready on RUN cycle 8 -> error=0.

Source files
------------

// File: rtl/fsm_par_ctrl_if.sv
// Handshake bundle between a sequencer slot, the parallel controller and its N child enables.
interface fsm_par_ctrl_if #(
   parameter int N = 2
) ();
   logic         valid;
   logic [N-1:0] child_en;
   logic [N-1:0] ready_child;
   logic [N-1:0] valid_child;
   logic         ready;
   logic [N-1:0] done_vec;
   logic         error;

   modport master (
      output valid, child_en, ready_child,
      input  valid_child, ready, done_vec, error
   );

   modport slave (
      input  valid, child_en, ready_child,
      output valid_child, ready, done_vec, error
   );
endinterface

// File: rtl/fsm_par_ctrl.sv
// Parallel-composition controller: launches N children together and reports ready once all are done.
// Optional RUN watchdog compiled in with `define FSM_PAR_TIMEOUT_EN.
module fsm_par_ctrl #(
   parameter int N       = 2,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic           clk,
   input  logic           reset,
   fsm_par_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t       state_r;
   state_t       state_nxt_s;
   logic [N-1:0] done_r;
   logic [N-1:0] hit_s;
   logic [N-1:0] valid_child_s;
   logic [N-1:0] done_vec_s;
   logic         all_done_s;
   logic         timeout_s;
   logic         ready_s;
   logic         error_s;

   // Same-cycle completions count together with the sticky bits.
   assign hit_s      = valid_child_s & bus.ready_child;
   assign all_done_s = &(done_r | hit_s);

`ifdef FSM_PAR_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_r;
   logic             err_r;

   // RUN-cycle watchdog counter, cleared whenever the FSM is outside RUN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == ST_RUN) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= {CNT_W{1'b0}};
      end
   end

   assign timeout_s = (state_r == ST_RUN) && (cnt_r == CNT_W'(TIMEOUT - 1));

   // Error flag: set only when expiry forces DONE, held through DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_r <= 1'b0;
      end else if (state_r == ST_RUN) begin
         err_r <= bus.valid && !all_done_s && timeout_s;
      end else if (state_r == ST_DONE) begin
         err_r <= err_r;
      end else begin
         err_r <= 1'b0;
      end
   end

   assign error_s = (state_r == ST_DONE) && err_r;
`else
   // Parameters stay visible so both builds share one instantiation.
   logic unused_cfg_s;
   assign unused_cfg_s = (TIMEOUT >= 1) && (CNT_W >= 1);
   assign timeout_s    = 1'b0;
   assign error_s      = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; abort beats completion and timeout.
   always_comb begin
      state_nxt_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (bus.valid) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!bus.valid) begin
               state_nxt_s = ST_IDLE;
            end else if (all_done_s || timeout_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (bus.valid) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Sticky done bits; disabled children are pre-marked done at launch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_r <= {N{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.valid) begin
                  done_r <= ~bus.child_en;
               end else begin
                  done_r <= {N{1'b0}};
               end
            end
            ST_RUN: begin
               if (!bus.valid) begin
                  done_r <= {N{1'b0}};
               end else begin
                  done_r <= done_r | hit_s;
               end
            end
            ST_DONE: begin
               if (!bus.valid) begin
                  done_r <= {N{1'b0}};
               end else begin
                  done_r <= done_r;
               end
            end
            default: begin
               done_r <= {N{1'b0}};
            end
         endcase
      end
   end

   // Moore output decode from state and done bits.
   always_comb begin
      valid_child_s = {N{1'b0}};
      done_vec_s    = {N{1'b0}};
      ready_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            valid_child_s = {N{1'b0}};
            done_vec_s    = {N{1'b0}};
            ready_s       = 1'b0;
         end
         ST_RUN: begin
            valid_child_s = ~done_r;
            done_vec_s    = done_r;
            ready_s       = 1'b0;
         end
         ST_DONE: begin
            valid_child_s = {N{1'b0}};
            done_vec_s    = done_r;
            ready_s       = 1'b1;
         end
         default: begin
            valid_child_s = {N{1'b0}};
            done_vec_s    = {N{1'b0}};
            ready_s       = 1'b0;
         end
      endcase
   end

   assign bus.valid_child = valid_child_s;
   assign bus.done_vec    = done_vec_s;
   assign bus.ready       = ready_s;
   assign bus.error       = error_s;

endmodule

// File: tb/tb_fsm_par_ctrl.sv
// Directed bench for fsm_par_ctrl with N=3; the watchdog section runs only with FSM_PAR_TIMEOUT_EN.
module tb_fsm_par_ctrl;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   fsm_par_ctrl_if #(.N(3)) bus_if ();

   fsm_par_ctrl #(.N(3), .TIMEOUT(8), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [2:0] vc, input logic rdy,
                          input logic [2:0] dv, input logic err);
      chk({tag, "_vc"},  {5'd0, bus_if.valid_child}, {5'd0, vc});
      chk({tag, "_rdy"}, {7'd0, bus_if.ready},       {7'd0, rdy});
      chk({tag, "_dv"},  {5'd0, bus_if.done_vec},    {5'd0, dv});
      chk({tag, "_err"}, {7'd0, bus_if.error},       {7'd0, err});
   endtask

   initial begin
      checks             = 0;
      errors             = 0;
      reset              = 1'b1;
      bus_if.valid       = 1'b0;
      bus_if.child_en    = 3'b000;
      bus_if.ready_child = 3'b000;
      tick(2);
      chk_out("reset", 3'b000, 1'b0, 3'b000, 1'b0);
      reset = 1'b0;
      tick(1);
      chk_out("idle", 3'b000, 1'b0, 3'b000, 1'b0);

      // Children ready on RUN cycles 1, 3, 2.
      bus_if.child_en = 3'b111;
      bus_if.valid    = 1'b1;
      tick(1);
      chk_out("t1_c1", 3'b111, 1'b0, 3'b000, 1'b0);
      bus_if.ready_child = 3'b001;
      tick(1);
      chk_out("t1_c2", 3'b110, 1'b0, 3'b001, 1'b0);
      bus_if.ready_child = 3'b100;
      tick(1);
      chk_out("t1_c3", 3'b010, 1'b0, 3'b101, 1'b0);
      bus_if.ready_child = 3'b010;
      tick(1);
      chk_out("t1_done", 3'b000, 1'b1, 3'b111, 1'b0);
      bus_if.ready_child = 3'b000;
      tick(1);
      chk_out("t1_hold", 3'b000, 1'b1, 3'b111, 1'b0);
      bus_if.valid = 1'b0;
      tick(1);
      chk_out("t1_idle", 3'b000, 1'b0, 3'b000, 1'b0);

      // All children ready before launch: one RUN cycle, ready two cycles after valid.
      bus_if.ready_child = 3'b111;
      tick(1);
      chk_out("t2_pre", 3'b000, 1'b0, 3'b000, 1'b0);
      bus_if.valid = 1'b1;
      tick(1);
      chk_out("t2_run", 3'b111, 1'b0, 3'b000, 1'b0);
      tick(1);
      chk_out("t2_done", 3'b000, 1'b1, 3'b111, 1'b0);
      bus_if.valid       = 1'b0;
      bus_if.ready_child = 3'b000;
      tick(1);
      chk_out("t2_idle", 3'b000, 1'b0, 3'b000, 1'b0);

      // Child 1 masked; a later child_en change must not relaunch it.
      bus_if.child_en = 3'b101;
      bus_if.valid    = 1'b1;
      tick(1);
      chk_out("t3_c1", 3'b101, 1'b0, 3'b010, 1'b0);
      bus_if.child_en    = 3'b111;
      bus_if.ready_child = 3'b001;
      tick(1);
      chk_out("t3_c2", 3'b100, 1'b0, 3'b011, 1'b0);
      bus_if.ready_child = 3'b100;
      tick(1);
      chk_out("t3_done", 3'b000, 1'b1, 3'b111, 1'b0);
      bus_if.valid       = 1'b0;
      bus_if.ready_child = 3'b000;
      tick(1);

      // All children masked.
      bus_if.child_en = 3'b000;
      bus_if.valid    = 1'b1;
      tick(1);
      chk_out("t3z_run", 3'b000, 1'b0, 3'b111, 1'b0);
      tick(1);
      chk_out("t3z_done", 3'b000, 1'b1, 3'b111, 1'b0);
      bus_if.valid = 1'b0;
      tick(1);
      chk_out("t3z_idle", 3'b000, 1'b0, 3'b000, 1'b0);

      // Abort with child 2 pending; abort wins over same-cycle completion.
      bus_if.child_en = 3'b111;
      bus_if.valid    = 1'b1;
      tick(1);
      bus_if.ready_child = 3'b011;
      tick(1);
      chk_out("t4_pend", 3'b100, 1'b0, 3'b011, 1'b0);
      bus_if.valid       = 1'b0;
      bus_if.ready_child = 3'b100;
      tick(1);
      chk_out("t4_abort", 3'b000, 1'b0, 3'b000, 1'b0);
      bus_if.valid       = 1'b1;
      bus_if.ready_child = 3'b111;
      tick(1);
      chk_out("t4_rerun", 3'b111, 1'b0, 3'b000, 1'b0);
      tick(1);
      chk_out("t4_redone", 3'b000, 1'b1, 3'b111, 1'b0);
      bus_if.valid       = 1'b0;
      bus_if.ready_child = 3'b000;
      tick(1);

      // Asynchronous reset mid-RUN, then relaunch from IDLE.
      bus_if.valid = 1'b1;
      tick(1);
      chk_out("t5_run", 3'b111, 1'b0, 3'b000, 1'b0);
      #2 reset = 1'b1;
      #1 chk_out("t5_rst_run", 3'b000, 1'b0, 3'b000, 1'b0);
      #1 reset = 1'b0;
      tick(1);
      chk_out("t5_relaunch", 3'b111, 1'b0, 3'b000, 1'b0);
      bus_if.ready_child = 3'b111;
      tick(1);
      chk_out("t5_done", 3'b000, 1'b1, 3'b111, 1'b0);
      #2 reset = 1'b1;
      #1 chk_out("t5_rst_done", 3'b000, 1'b0, 3'b000, 1'b0);
      bus_if.valid       = 1'b0;
      bus_if.ready_child = 3'b000;
      tick(1);
      reset = 1'b0;
      tick(1);
      chk_out("t5_idle", 3'b000, 1'b0, 3'b000, 1'b0);

`ifdef FSM_PAR_TIMEOUT_EN
      // Child 1 never ready: expiry after 8 RUN cycles.
      bus_if.valid       = 1'b1;
      bus_if.ready_child = 3'b101;
      tick(1);
      tick(7);
      chk_out("t6_c8", 3'b010, 1'b0, 3'b101, 1'b0);
      tick(1);
      chk_out("t6_to", 3'b000, 1'b1, 3'b101, 1'b1);
      tick(1);
      chk_out("t6_to_hold", 3'b000, 1'b1, 3'b101, 1'b1);
      bus_if.valid = 1'b0;
      tick(1);
      chk_out("t6_idle", 3'b000, 1'b0, 3'b000, 1'b0);

      // Child 1 ready in the expiring cycle: completion wins.
      bus_if.valid = 1'b1;
      tick(1);
      tick(7);
      chk_out("t6b_c8", 3'b010, 1'b0, 3'b101, 1'b0);
      bus_if.ready_child = 3'b111;
      tick(1);
      chk_out("t6b_done", 3'b000, 1'b1, 3'b111, 1'b0);
      bus_if.valid       = 1'b0;
      bus_if.ready_child = 3'b000;
      tick(1);
`else
      // Without the watchdog RUN waits indefinitely.
      bus_if.valid       = 1'b1;
      bus_if.ready_child = 3'b101;
      tick(1);
      tick(12);
      chk_out("t6_wait", 3'b010, 1'b0, 3'b101, 1'b0);
      bus_if.valid = 1'b0;
      tick(1);
      chk_out("t6_idle", 3'b000, 1'b0, 3'b000, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
